// File: rtl/calc_pkg.sv
// Shared opcodes, sequencer states and widths for the calculator core.
package calc_pkg;

  localparam int RESULT_W = 24;
  localparam int OPREG_W  = 8;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_DIV  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Single-cycle operations; MUL/DIV are sequenced by calc_core instead.
  function automatic logic [RESULT_W-1:0] aluSimple(input logic [2:0]          op,
                                                    input logic [RESULT_W-1:0] acc,
                                                    input logic [OPREG_W-1:0]  b);
    logic [RESULT_W-1:0] bx;
    bx = RESULT_W'(b);
    case (op)
      OP_CLR:  aluSimple = '0;
      OP_LOAD: aluSimple = bx;
      OP_ADD:  aluSimple = acc + bx;
      OP_SUB:  aluSimple = acc - bx;
      OP_AND:  aluSimple = acc & bx;
      OP_OR:   aluSimple = acc | bx;
      default: aluSimple = acc;
    endcase
  endfunction

endpackage

// File: rtl/calc_core_if.sv
// Switch/key inputs and display_driver-facing outputs of the calculator core.
interface calc_core_if;
  import calc_pkg::*;

  logic [OPREG_W-1:0]  Switches;
  logic                KeyOpReg_n;
  logic                KeyOpCode_n;
  logic [OPREG_W-1:0]  OpReg;
  logic                ShowOpReg;
  logic [2:0]          OpCode;
  logic                ShowOpCode;
  logic [RESULT_W-1:0] OpResult;
  logic                Busy;

  modport master (
    output Switches, KeyOpReg_n, KeyOpCode_n,
    input  OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult, Busy
  );

  modport slave (
    input  Switches, KeyOpReg_n, KeyOpCode_n,
    output OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult, Busy
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low push button; emits a one-cycle
// pulse when the debounced level goes from released to pressed.
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic oneMsPulse,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt measures how many ms the synced level has disagreed with r_level;
  // any return to agreement restarts the measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (oneMsPulse) begin
        if (r_cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/calc_core.sv
// Operand/opcode entry and accumulator engine with sequential 8-step multiply
// and 24-step restoring divide; all outputs registered.
module calc_core
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        oneMsPulse,
  calc_core_if.slave  bus
);

  logic w_pressReg;
  logic w_pressCode;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_keyOpReg (
    .clk        (clk),
    .reset_n    (reset_n),
    .oneMsPulse (oneMsPulse),
    .key_n      (bus.KeyOpReg_n),
    .press      (w_pressReg)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_keyOpCode (
    .clk        (clk),
    .reset_n    (reset_n),
    .oneMsPulse (oneMsPulse),
    .key_n      (bus.KeyOpCode_n),
    .press      (w_pressCode)
  );

  state_t              r_state;
  logic [4:0]          r_iter;
  logic [OPREG_W-1:0]  r_opReg;
  logic                r_showOpReg;
  logic [2:0]          r_opCode;
  logic                r_showOpCode;
  logic [RESULT_W-1:0] r_opResult;
  logic                r_busy;
  logic [RESULT_W-1:0] r_acc;
  logic [RESULT_W-1:0] r_mcand;
  logic [OPREG_W-1:0]  r_mulB;
  logic [OPREG_W-1:0]  r_divisor;
  logic [RESULT_W-1:0] r_quot;
  logic [OPREG_W-1:0]  r_rem;

  logic [OPREG_W-1:0]  w_b;
  logic [2:0]          w_op;
  logic [RESULT_W-1:0] w_mulSum;
  logic [OPREG_W:0]    w_remShift;
  logic [OPREG_W:0]    w_remTrial;
  logic                w_divGe;
  logic [OPREG_W-1:0]  w_remNext;
  logic [RESULT_W-1:0] w_quotNext;

  // A simultaneous operand press supplies the fresh switch value as B.
  assign w_b        = w_pressReg ? bus.Switches : r_opReg;
  assign w_op       = bus.Switches[2:0];
  assign w_mulSum   = r_acc + (r_mulB[0] ? r_mcand : '0);
  assign w_remShift = {r_rem, r_quot[RESULT_W-1]};
  assign w_remTrial = w_remShift - {1'b0, r_divisor};
  assign w_divGe    = ~w_remTrial[OPREG_W];
  assign w_remNext  = w_divGe ? w_remTrial[OPREG_W-1:0] : w_remShift[OPREG_W-1:0];
  assign w_quotNext = {r_quot[RESULT_W-2:0], w_divGe};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_iter       <= '0;
      r_opReg      <= '0;
      r_showOpReg  <= 1'b0;
      r_opCode     <= '0;
      r_showOpCode <= 1'b0;
      r_opResult   <= '0;
      r_busy       <= 1'b0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mulB       <= '0;
      r_divisor    <= '0;
      r_quot       <= '0;
      r_rem        <= '0;
    end else begin
      r_showOpReg  <= 1'b0;
      r_showOpCode <= 1'b0;
      if (w_pressReg) begin
        r_opReg     <= bus.Switches;
        r_showOpReg <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pressCode) begin
            r_opCode     <= w_op;
            r_showOpCode <= 1'b1;
            r_iter       <= '0;
            case (w_op)
              OP_MUL: begin
                r_mcand <= r_opResult;
                r_mulB  <= w_b;
                r_acc   <= '0;
                r_busy  <= 1'b1;
                r_state <= ST_MUL;
              end
              OP_DIV: begin
                if (w_b == '0) begin
                  r_opResult <= '1;
                end else begin
                  r_divisor <= w_b;
                  r_quot    <= r_opResult;
                  r_rem     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_DIV;
                end
              end
              default: r_opResult <= aluSimple(w_op, r_opResult, w_b);
            endcase
          end
        end
        ST_MUL: begin
          r_acc   <= w_mulSum;
          r_mcand <= r_mcand << 1;
          r_mulB  <= r_mulB >> 1;
          r_iter  <= r_iter + 5'd1;
          if (r_iter == 5'd7) begin
            r_opResult <= w_mulSum;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        ST_DIV: begin
          r_rem  <= w_remNext;
          r_quot <= w_quotNext;
          r_iter <= r_iter + 5'd1;
          if (r_iter == 5'd23) begin
            r_opResult <= w_quotNext;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.OpReg      = r_opReg;
  assign bus.ShowOpReg  = r_showOpReg;
  assign bus.OpCode     = r_opCode;
  assign bus.ShowOpCode = r_showOpCode;
  assign bus.OpResult   = r_opResult;
  assign bus.Busy       = r_busy;

endmodule

// File: tb/tb_calc_core.sv
// Randomised scoreboard bench for calc_core: stimulus pushes expectations from
// a plain-arithmetic calculator model; a negedge monitor pops and compares.
module tb_calc_core;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic oneMsPulse = 1'b0;

  calc_core_if bus ();

  calc_core #(.DEBOUNCE_MS(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .oneMsPulse (oneMsPulse),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    bit          resultNow;
    logic [23:0] result;
  } codeExp_t;

  int errors = 0;
  int checks = 0;
  int tickPeriod = 50;

  logic [7:0]  regQ[$];
  codeExp_t    codeQ[$];
  logic [23:0] busyQ[$];
  int          busyLenQ[$];
  logic [23:0] mAcc = '0;
  logic [7:0]  mOpReg = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic flagUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  function automatic logic [23:0] refCalc(input int op, input logic [23:0] acc, input logic [7:0] b);
    longint a, bb, r;
    a  = longint'(acc);
    bb = longint'(b);
    case (op)
      0:       r = 0;
      1:       r = bb;
      2:       r = a + bb;
      3:       r = a - bb;
      4:       r = a & bb;
      5:       r = a | bb;
      6:       r = a * bb;
      default: r = (bb == 0) ? longint'(24'hFFFFFF) : a / bb;
    endcase
    return r[23:0];
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model update and expectation push for an opcode that will be accepted.
  task automatic expectOpCode(input logic [2:0] op);
    codeExp_t e;
    logic [23:0] r;
    r = refCalc(int'(op), mAcc, mOpReg);
    e.op = op;
    if (op == OP_MUL || (op == OP_DIV && mOpReg != 8'd0)) begin
      e.resultNow = 1'b0;
      e.result    = mAcc;
      busyQ.push_back(r);
      busyLenQ.push_back(op == OP_MUL ? 8 : 24);
    end else begin
      e.resultNow = 1'b1;
      e.result    = r;
    end
    codeQ.push_back(e);
    mAcc = r;
  endtask

  task automatic pressOpReg(input logic [7:0] val);
    bus.Switches = val;
    regQ.push_back(val);
    mOpReg = val;
    bus.KeyOpReg_n = 1'b0;
    waitCycles(150);
    bus.KeyOpReg_n = 1'b1;
    waitCycles(150);
  endtask

  task automatic applyStimulus(input logic [2:0] op);
    logic [4:0] hi;
    hi = 5'($urandom_range(0, 31));
    expectOpCode(op);
    bus.Switches = {hi, op};
    bus.KeyOpCode_n = 1'b0;
    waitCycles(150);
    bus.KeyOpCode_n = 1'b1;
    waitCycles(150);
  endtask

  task automatic pressBoth(input logic [7:0] val);
    regQ.push_back(val);
    mOpReg = val;
    expectOpCode(val[2:0]);
    bus.Switches = val;
    bus.KeyOpReg_n = 1'b0;
    bus.KeyOpCode_n = 1'b0;
    waitCycles(150);
    bus.KeyOpReg_n = 1'b1;
    bus.KeyOpCode_n = 1'b1;
    waitCycles(150);
  endtask

  task automatic waitShowOpCode(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ShowOpCode;
    end
    if (!seen) flagUnexpected({name, "_timeout"});
  endtask

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (cnt >= tickPeriod - 1) begin
        oneMsPulse = 1'b1;
        cnt = 0;
      end else begin
        oneMsPulse = 1'b0;
        cnt++;
      end
    end
  end

  // Monitor: consumes expectations whenever the DUT presents an event.
  initial begin
    bit prevBusy;
    int busyLen;
    logic [23:0] heldExp;
    codeExp_t e;
    prevBusy = 1'b0;
    busyLen  = 0;
    heldExp  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevBusy = 1'b0;
        busyLen  = 0;
      end else begin
        if (bus.ShowOpReg) begin
          if (regQ.size() == 0) flagUnexpected("ShowOpReg");
          else checkOutput("OpReg", 32'(bus.OpReg), 32'(regQ.pop_front()));
        end
        if (bus.ShowOpCode) begin
          if (codeQ.size() == 0) begin
            flagUnexpected("ShowOpCode");
          end else begin
            e = codeQ.pop_front();
            checkOutput("OpCode", 32'(bus.OpCode), 32'(e.op));
            if (e.resultNow) begin
              checkOutput("OpResult", 32'(bus.OpResult), 32'(e.result));
              checkOutput("BusyAfterOp", 32'(bus.Busy), 32'd0);
            end else begin
              checkOutput("BusyStart", 32'(bus.Busy), 32'd1);
              heldExp = e.result;
            end
          end
        end
        if (bus.Busy) begin
          busyLen++;
          checkOutput("OpResultHeld", 32'(bus.OpResult), 32'(heldExp));
        end
        if (prevBusy && !bus.Busy) begin
          if (busyQ.size() == 0) begin
            flagUnexpected("BusyFall");
          end else begin
            checkOutput("MulDivResult", 32'(bus.OpResult), 32'(busyQ.pop_front()));
            checkOutput("BusyCycles", 32'(busyLen), 32'(busyLenQ.pop_front()));
          end
          busyLen = 0;
        end
        prevBusy = bus.Busy;
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] val;
    bus.Switches    = '0;
    bus.KeyOpReg_n  = 1'b1;
    bus.KeyOpCode_n = 1'b1;
    waitCycles(3);
    checkOutput("ResetOpResult", 32'(bus.OpResult), 32'd0);
    checkOutput("ResetBusy", 32'(bus.Busy), 32'd0);
    reset_n = 1'b1;
    waitCycles(2);
    checkOutput("PostResetOpReg", 32'(bus.OpReg), 32'd0);
    checkOutput("PostResetOpCode", 32'(bus.OpCode), 32'd0);
    checkOutput("PostResetShow", 32'({bus.ShowOpReg, bus.ShowOpCode}), 32'd0);

    $display("[TB] bounced operand press");
    bus.Switches = 8'h2A;
    regQ.push_back(8'h2A);
    mOpReg = 8'h2A;
    bus.KeyOpReg_n = 1'b0;
    waitCycles(50);
    bus.KeyOpReg_n = 1'b1;
    waitCycles(5);
    bus.KeyOpReg_n = 1'b0;
    waitCycles(200);
    bus.KeyOpReg_n = 1'b1;
    waitCycles(30);
    bus.KeyOpReg_n = 1'b0;
    waitCycles(5);
    bus.KeyOpReg_n = 1'b1;
    waitCycles(200);
    checkOutput("BounceOpReg", 32'(bus.OpReg), 32'h2A);
    checkOutput("BounceQueue", 32'(regQ.size()), 32'd0);

    $display("[TB] load / add / sub");
    pressOpReg(8'h05);
    applyStimulus(OP_LOAD);
    pressOpReg(8'h07);
    applyStimulus(OP_ADD);
    checkOutput("LoadAdd", 32'(bus.OpResult), 32'h00000C);
    applyStimulus(OP_CLR);
    pressOpReg(8'h01);
    applyStimulus(OP_SUB);
    checkOutput("SubWrap", 32'(bus.OpResult), 32'hFFFFFF);

    $display("[TB] multiply");
    pressOpReg(8'h12);
    applyStimulus(OP_LOAD);
    pressOpReg(8'h10);
    applyStimulus(OP_MUL);
    applyStimulus(OP_MUL);
    pressOpReg(8'h34);
    applyStimulus(OP_OR);
    checkOutput("MulSetup", 32'(bus.OpResult), 32'h001234);
    pressOpReg(8'h10);
    applyStimulus(OP_MUL);
    checkOutput("Mul", 32'(bus.OpResult), 32'h012340);

    $display("[TB] divide");
    applyStimulus(OP_CLR);
    pressOpReg(8'h7D);
    applyStimulus(OP_LOAD);
    pressOpReg(8'h08);
    applyStimulus(OP_MUL);
    pressOpReg(8'h07);
    applyStimulus(OP_DIV);
    checkOutput("Div", 32'(bus.OpResult), 32'h00008E);
    pressOpReg(8'h00);
    applyStimulus(OP_DIV);
    checkOutput("DivByZero", 32'(bus.OpResult), 32'hFFFFFF);

    $display("[TB] simultaneous presses");
    applyStimulus(OP_CLR);
    pressBoth(8'h0A);
    checkOutput("BothPress", 32'(bus.OpResult), 32'h00000A);

    $display("[TB] opcode press dropped while busy");
    pressOpReg(8'hC8);
    applyStimulus(OP_LOAD);
    pressOpReg(8'h03);
    expectOpCode(OP_DIV);
    bus.Switches = 8'h07;
    bus.KeyOpCode_n = 1'b0;
    waitShowOpCode("DropSetup");
    tickPeriod = 1;
    bus.KeyOpCode_n = 1'b1;
    waitCycles(6);
    bus.Switches = 8'h02;
    bus.KeyOpCode_n = 1'b0;
    waitCycles(40);
    bus.KeyOpCode_n = 1'b1;
    waitCycles(20);
    tickPeriod = 50;
    waitCycles(150);
    checkOutput("DropOpCode", 32'(bus.OpCode), 32'd7);
    checkOutput("DropResult", 32'(bus.OpResult), 32'd66);

    $display("[TB] randomised operations");
    for (int i = 0; i < 30; i++) begin
      val = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      pressOpReg(val);
      applyStimulus(3'($urandom_range(0, 7)));
    end

    $display("[TB] reset during divide");
    pressOpReg(8'hF0);
    applyStimulus(OP_LOAD);
    pressOpReg(8'h03);
    expectOpCode(OP_DIV);
    bus.Switches = 8'h07;
    bus.KeyOpCode_n = 1'b0;
    waitShowOpCode("ResetSetup");
    waitCycles(9);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("AbortOpResult", 32'(bus.OpResult), 32'd0);
    checkOutput("AbortBusy", 32'(bus.Busy), 32'd0);
    checkOutput("AbortOpReg", 32'(bus.OpReg), 32'd0);
    checkOutput("AbortOpCode", 32'(bus.OpCode), 32'd0);
    bus.KeyOpCode_n = 1'b1;
    busyQ.delete();
    busyLenQ.delete();
    mAcc = '0;
    mOpReg = '0;
    waitCycles(5);
    reset_n = 1'b1;
    waitCycles(150);
    checkOutput("IdleAfterReset", 32'(bus.Busy), 32'd0);
    pressOpReg(8'h55);
    applyStimulus(OP_LOAD);
    checkOutput("LoadAfterReset", 32'(bus.OpResult), 32'h55);

    waitCycles(50);
    checkOutput("QueuesEmpty", 32'(regQ.size() + codeQ.size() + busyQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
